// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receive path.
// Holds the frame-state encoding, the scancode-set-2 prefix and status
// byte codes, the ps2_key bit positions and small byte-level helpers.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_e;

    // Prefix bytes and the number of Pause bytes swallowed after E1
    localparam logic [7:0] PFX_EXT    = 8'hE0;
    localparam logic [7:0] PFX_REL    = 8'hF0;
    localparam logic [7:0] PFX_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Keyboard status/protocol bytes that never become key events
    localparam logic [7:0] CODE_NUL  = 8'h00;
    localparam logic [7:0] CODE_OVR  = 8'hFF;
    localparam logic [7:0] CODE_BAT  = 8'hAA;
    localparam logic [7:0] CODE_ACK  = 8'hFA;
    localparam logic [7:0] CODE_RSND = 8'hFE;
    localparam logic [7:0] CODE_ECHO = 8'hEE;

    // ps2_key bit positions
    localparam int unsigned KEY_TOG = 10;
    localparam int unsigned KEY_PRS = 9;
    localparam int unsigned KEY_EXT = 8;

    // PS/2 uses odd parity over the eight data bits plus the parity bit
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

    // True for bytes that reset the prefix state without producing an event
    function automatic logic is_ignored_code(input logic [7:0] b);
        logic hit;
        case (b)
            CODE_NUL, CODE_OVR, CODE_BAT,
            CODE_ACK, CODE_RSND, CODE_ECHO: hit = 1'b1;
            default:                        hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 serial frame receiver.
// Synchronises the raw clock/data pins, glitch-filters the clock, and
// assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop).
// Ports:
//   clk_sys   system clock
//   I_RESETn  asynchronous active-low reset
//   ps2_clk   raw PS/2 clock (asynchronous, idle high)
//   ps2_data  raw PS/2 data  (asynchronous, idle high)
//   rx_byte   last correctly received byte
//   rx_valid  one-cycle strobe when rx_byte updates
//   rx_err    one-cycle strobe on bad start, parity, stop or timeout
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 2500,
    parameter int unsigned TO_W        = 12
) (
    input  logic       clk_sys,
    input  logic       I_RESETn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);

    logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          filt_q, filt_d;
    logic          fe_s;

    frame_state_e  state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TO_W-1:0] tocnt_q, tocnt_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_err_q, rx_err_d;

    // Two-flop synchronisers; preset to the idle-high line level
    always_ff @(posedge clk_sys or negedge I_RESETn) begin
        if (!I_RESETn) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
        end
    end

    // Clock filter: the level flips only after FILTER_LEN consecutive differing samples
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q == filt_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d     = clk_sync_q;
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    // Falling edge of the filtered clock, seen in the cycle it is committed
    assign fe_s = filt_q & ~filt_d;

    // Frame FSM and timeout next-state logic
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        tocnt_d    = tocnt_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (fe_s) begin
                    if (!data_sync_q) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (fe_s) begin
                    shreg_d = {data_sync_q, shreg_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (fe_s) begin
                    par_d   = data_sync_q;
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (fe_s) begin
                    if (data_sync_q && odd_parity_ok(shreg_q, par_q)) begin
                        rx_byte_d  = shreg_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Mid-frame watchdog: a stalled keyboard must not wedge the receiver
        if (state_q == IDLE) begin
            tocnt_d = '0;
        end else if (fe_s) begin
            tocnt_d = '0;
        end else if (tocnt_q == TO_W'(TIMEOUT_CYC)) begin
            state_d    = IDLE;
            rx_err_d   = 1'b1;
            rx_valid_d = 1'b0;
            tocnt_d    = '0;
        end else begin
            tocnt_d = tocnt_q + 1'b1;
        end
    end

    // State registers for filter, frame FSM and outputs
    always_ff @(posedge clk_sys or negedge I_RESETn) begin
        if (!I_RESETn) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= IDLE;
            bitcnt_q   <= 3'd0;
            shreg_q    <= 8'h00;
            par_q      <= 1'b0;
            tocnt_q    <= '0;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tocnt_q    <= tocnt_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign rx_byte  = rx_byte_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: raw pins in, 11-bit ps2_key event word out.
// Wraps the frame receiver and applies scancode-set-2 prefix handling
// (E0 extended, F0 release, E1 Pause swallowed, status bytes ignored).
// Ports:
//   clk_sys   system clock
//   I_RESETn  asynchronous active-low reset
//   ps2_clk   raw PS/2 clock
//   ps2_data  raw PS/2 data
//   ps2_key   [10] toggle per event, [9] pressed, [8] extended, [7:0] code
//   rx_byte   last good raw byte (debug)
//   rx_valid  strobe when rx_byte updates
//   rx_err    strobe on any receive error
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 2500,
    parameter int unsigned TO_W        = 12
) (
    input  logic        clk_sys,
    input  logic        I_RESETn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        rx_err
);

    logic [7:0]  rx_byte_s;
    logic        rx_valid_s;
    logic        rx_err_s;

    logic [10:0] key_q, key_d;
    logic        ext_q, ext_d;
    logic        rel_q, rel_d;
    logic [2:0]  skip_q, skip_d;

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_rx (
        .clk_sys  (clk_sys),
        .I_RESETn (I_RESETn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte_s),
        .rx_valid (rx_valid_s),
        .rx_err   (rx_err_s)
    );

    // Prefix decoder; errors leave the prefix state alone so a resent byte completes it
    always_comb begin
        key_d  = key_q;
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        if (rx_valid_s) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (rx_byte_s == PFX_PAUSE) begin
                skip_d = PAUSE_SKIP;
                ext_d  = 1'b0;
                rel_d  = 1'b0;
            end else if (rx_byte_s == PFX_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte_s == PFX_REL) begin
                rel_d = 1'b1;
            end else if (is_ignored_code(rx_byte_s)) begin
                ext_d = 1'b0;
                rel_d = 1'b0;
            end else begin
                key_d[KEY_TOG] = ~key_q[KEY_TOG];
                key_d[KEY_PRS] = ~rel_q;
                key_d[KEY_EXT] = ext_q;
                key_d[7:0]     = rx_byte_s;
                ext_d          = 1'b0;
                rel_d          = 1'b0;
            end
        end else begin
            key_d = key_q;
        end
    end

    // Decoder state and event word registers
    always_ff @(posedge clk_sys or negedge I_RESETn) begin
        if (!I_RESETn) begin
            key_q  <= 11'h000;
            ext_q  <= 1'b0;
            rel_q  <= 1'b0;
            skip_q <= 3'd0;
        end else begin
            key_q  <= key_d;
            ext_q  <= ext_d;
            rel_q  <= rel_d;
            skip_q <= skip_d;
        end
    end

    assign ps2_key  = key_q;
    assign rx_byte  = rx_byte_s;
    assign rx_valid = rx_valid_s;
    assign rx_err   = rx_err_s;

endmodule
